booth_pp_accum_18x18: RTL and testbench

- Sequential consumer of the ten 20-bit Booth radix-4 partial products from the 18x18 partial-product generator.
- Captures one set of partial products through a valid/ready handshake.
- Sums them iteratively, one per cycle, each shifted by 2*k, into a 36-bit product.
- Presents the product on a valid/ready output. This is the low-area, multi-cycle back end of the mult18x18 path.

---
 rtl/booth_pp_accum_18x18_if.sv | 27 ++
 rtl/booth_pp_accum_18x18.sv | 104 ++++++++++
 tb/tb_booth_pp_accum_18x18.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/booth_pp_accum_18x18_if.sv
// rtl/booth_pp_accum_18x18_if.sv - handshake and partial-product bundle for the Booth accumulator
interface booth_pp_accum_18x18_if #(
  parameter int PP_W   = 20,
  parameter int PROD_W = 36
);
  logic              i_clear;
  logic              i_valid;
  logic              o_ready;
  logic [PP_W-1:0]   i_pp1, i_pp2, i_pp3, i_pp4, i_pp5;
  logic [PP_W-1:0]   i_pp6, i_pp7, i_pp8, i_pp9, i_pp10;
  logic              o_valid;
  logic              i_ready;
  logic [PROD_W-1:0] o_product;
  logic              o_busy;

  modport master (
    output i_clear, i_valid, i_ready,
    output i_pp1, i_pp2, i_pp3, i_pp4, i_pp5, i_pp6, i_pp7, i_pp8, i_pp9, i_pp10,
    input  o_ready, o_valid, o_product, o_busy
  );

  modport slave (
    input  i_clear, i_valid, i_ready,
    input  i_pp1, i_pp2, i_pp3, i_pp4, i_pp5, i_pp6, i_pp7, i_pp8, i_pp9, i_pp10,
    output o_ready, o_valid, o_product, o_busy
  );
endinterface

// File: rtl/booth_pp_accum_18x18.sv
// rtl/booth_pp_accum_18x18.sv - iterative adder of ten Booth radix-4 partial products into a 36-bit product
module booth_pp_accum_18x18 #(
  parameter int NUM_PP = 10,
  parameter int PP_W   = 20,
  parameter int PROD_W = 36
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  booth_pp_accum_18x18_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_PP - 1);

  state_t            state_q, state_d;
  logic [PP_W-1:0]   pp_q  [NUM_PP];
  logic [PP_W-1:0]   pp_in [NUM_PP];
  logic [3:0]        idx_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] product_q;
  logic              valid_q;
  logic [PP_W-1:0]   pp_sel;
  logic [PROD_W-1:0] term;
  logic [PROD_W-1:0] acc_next;
  logic              accept;

  assign pp_in[0] = bus.i_pp1;
  assign pp_in[1] = bus.i_pp2;
  assign pp_in[2] = bus.i_pp3;
  assign pp_in[3] = bus.i_pp4;
  assign pp_in[4] = bus.i_pp5;
  assign pp_in[5] = bus.i_pp6;
  assign pp_in[6] = bus.i_pp7;
  assign pp_in[7] = bus.i_pp8;
  assign pp_in[8] = bus.i_pp9;
  assign pp_in[9] = bus.i_pp10;

  always_comb begin
    pp_sel = '0;
    if (idx_q <= LAST_IDX) pp_sel = pp_q[idx_q];
  end

  // Sign-extend to the product width first; bits shifted past bit 35 drop out mod 2^36.
  assign term     = {{(PROD_W-PP_W){pp_sel[PP_W-1]}}, pp_sel} << {idx_q, 1'b0};
  assign acc_next = acc_q + term;
  assign accept   = (state_q == IDLE) && bus.i_valid && !bus.i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid)       state_d = ACC;
      ACC:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.i_ready)       state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
    if (bus.i_clear) state_d = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_PP; k++) pp_q[k] <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else if (bus.i_clear) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int k = 0; k < NUM_PP; k++) pp_q[k] <= pp_in[k];
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ACC: begin
          acc_q <= acc_next;
          if (idx_q == LAST_IDX) begin
            product_q <= acc_next;
            valid_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.i_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready   = (state_q == IDLE);
  assign bus.o_busy    = (state_q == ACC);
  assign bus.o_valid   = valid_q;
  assign bus.o_product = product_q;
endmodule

// File: tb/tb_booth_pp_accum_18x18.sv
// tb/tb_booth_pp_accum_18x18.sv - directed self-checking bench for booth_pp_accum_18x18
module tb_booth_pp_accum_18x18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  booth_pp_accum_18x18_if bus ();

  booth_pp_accum_18x18 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_pps(input logic [19:0] p [10]);
    bus.i_pp1 = p[0]; bus.i_pp2 = p[1]; bus.i_pp3 = p[2]; bus.i_pp4 = p[3]; bus.i_pp5  = p[4];
    bus.i_pp6 = p[5]; bus.i_pp7 = p[6]; bus.i_pp8 = p[7]; bus.i_pp9 = p[8]; bus.i_pp10 = p[9];
  endtask

  // Presents a set, checks the exact latency of o_valid, then the product and handoff.
  task automatic run_op(input string tag, input logic [19:0] p [10], input logic [35:0] exp);
    logic [19:0] junk [10];
    set_pps(p);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check({tag, "_ready_low"}, 36'(bus.o_ready), 36'd0);
    check({tag, "_busy"}, 36'(bus.o_busy), 36'd1);
    for (int k = 0; k < 10; k++) junk[k] = 20'hAAAAA;
    set_pps(junk);
    for (int c = 1; c <= 9; c++) begin
      bus.i_valid = (c == 3);
      @(negedge clk);
      if (bus.o_valid) check({tag, "_early_valid"}, 36'(bus.o_valid), 36'd0);
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid_n10"}, 36'(bus.o_valid), 36'd1);
    check({tag, "_product"}, bus.o_product, exp);
    check({tag, "_ready_done"}, 36'(bus.o_ready), 36'd0);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({tag, "_ready_idle"}, 36'(bus.o_ready), 36'd1);
    check({tag, "_valid_drop"}, 36'(bus.o_valid), 36'd0);
  endtask

  logic [19:0] v [10];
  bit          saw_valid;

  initial begin
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 10; k++) v[k] = '0;
    set_pps(v);
    #12;
    check("rst_ready", 36'(bus.o_ready), 36'd1);
    check("rst_valid", 36'(bus.o_valid), 36'd0);
    check("rst_busy", 36'(bus.o_busy), 36'd0);
    check("rst_product", bus.o_product, 36'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 3*5: pp1=3, pp2=3 -> 3 + 3*4
    for (int k = 0; k < 10; k++) v[k] = '0;
    v[0] = 20'h00003; v[1] = 20'h00003;
    run_op("u3x5", v, 36'h00000000F);

    for (int k = 0; k < 10; k++) v[k] = '0;
    v[0] = 20'h00001;
    run_op("sm1xm1", v, 36'h000000001);

    // 3FFFF*3FFFF unsigned: digits -1 (k=0) and +1 (k=9)
    for (int k = 0; k < 10; k++) v[k] = '0;
    v[0] = 20'hC0001; v[9] = 20'h3FFFF;
    run_op("umax", v, 36'hFFFF80001);

    // -2^17 * -2^17 signed: single digit -2 at k=8 -> pp9 = +2^18
    for (int k = 0; k < 10; k++) v[k] = '0;
    v[8] = 20'h40000;
    run_op("smin", v, 36'h400000000);

    // negative pp at weight 4 must sign-extend: -1*4 mod 2^36
    for (int k = 0; k < 10; k++) v[k] = '0;
    v[1] = 20'hFFFFF;
    run_op("sext", v, 36'hFFFFFFFFC);

    // backpressure in DONE
    for (int k = 0; k < 10; k++) v[k] = '0;
    v[0] = 20'h00003; v[1] = 20'h00003;
    set_pps(v);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 36'(bus.o_valid), 36'd1);
      check("bp_product", bus.o_product, 36'h00000000F);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    check("bp_ready", 36'(bus.o_ready), 36'd1);
    check("bp_valid_drop", 36'(bus.o_valid), 36'd0);

    // abort during ACC
    for (int k = 0; k < 10; k++) v[k] = '0;
    v[0] = 20'h00007;
    set_pps(v);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    check("clr_ready", 36'(bus.o_ready), 36'd1);
    check("clr_busy", 36'(bus.o_busy), 36'd0);
    check("clr_product_kept", bus.o_product, 36'h00000000F);
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_valid) saw_valid = 1'b1;
    end
    check("clr_no_valid", 36'(saw_valid), 36'd0);

    // async reset mid-ACC, sampled before the next clock edge
    v[0] = 20'h00009;
    set_pps(v);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 36'(bus.o_ready), 36'd1);
    check("arst_busy", 36'(bus.o_busy), 36'd0);
    check("arst_valid", 36'(bus.o_valid), 36'd0);
    check("arst_product", bus.o_product, 36'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) v[k] = '0;
    v[0] = 20'h00003; v[1] = 20'h00003;
    run_op("post_rst", v, 36'h00000000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
